// File: rtl/seq_chunk_addr.sv
// Multi-cycle adder/subtractor: adds CHUNK bits per clock through a ripple-carry chain.
// Define SEQ_CHUNK_ADDR_OVF_EN to build the signed-overflow flag; otherwise ovf is tied to 0.
module seq_chunk_addr #(
   parameter int WIDTH = 16,
   parameter int CHUNK = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic             sub,
   input  logic [WIDTH-1:0] in1,
   input  logic [WIDTH-1:0] in2,
   input  logic             cin,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] out,
   output logic             cout,
   output logic             ovf
);

   localparam int N     = WIDTH / CHUNK;
   localparam int IDX_W = (N > 1) ? $clog2(N) : 1;

   typedef enum logic {IDLE, BUSY} state_t;

   state_t             state_q, state_d;
   logic [WIDTH-1:0]   a_q, a_d, b_q, b_d, res_q, res_d, out_q, out_d;
   logic [IDX_W-1:0]   idx_q, idx_d;
   logic               sub_q, sub_d, carry_q, carry_d;
   logic               done_q, done_d, cout_q, cout_d;
   logic [CHUNK-1:0]   ca, cb, csum;
   logic [CHUNK:0]     c;
   logic               last;

   // Chunk datapath: c[CHUNK-1] is the carry into the chunk MSB, c[CHUNK] the carry out.
   always_comb begin
      ca   = a_q[idx_q*CHUNK +: CHUNK];
      cb   = b_q[idx_q*CHUNK +: CHUNK];
      c    = '0;
      csum = '0;
      c[0] = carry_q | (sub_q & (idx_q == '0));
      for (int i = 0; i < CHUNK; i++) begin
         csum[i]  = ca[i] ^ cb[i] ^ c[i];
         c[i+1]   = (ca[i] & cb[i]) | (c[i] & (ca[i] ^ cb[i]));
      end
      last = (idx_q == IDX_W'(N-1));
   end

   always_comb begin
      state_d = state_q;
      a_d     = a_q;
      b_d     = b_q;
      sub_d   = sub_q;
      carry_d = carry_q;
      idx_d   = idx_q;
      res_d   = res_q;
      out_d   = out_q;
      cout_d  = cout_q;
      done_d  = 1'b0;
      case (state_q)
         IDLE: begin
            if (start) begin
               a_d     = in1;
               b_d     = sub ? ~in2 : in2;
               sub_d   = sub;
               carry_d = sub ? 1'b1 : cin;
               idx_d   = '0;
               state_d = BUSY;
            end
         end
         BUSY: begin
            res_d[idx_q*CHUNK +: CHUNK] = csum;
            carry_d = c[CHUNK];
            idx_d   = idx_q + 1'b1;
            if (last) begin
               idx_d   = '0;
               out_d   = res_d;
               cout_d  = c[CHUNK];
               done_d  = 1'b1;
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         a_q     <= '0;
         b_q     <= '0;
         sub_q   <= 1'b0;
         carry_q <= 1'b0;
         idx_q   <= '0;
         res_q   <= '0;
         out_q   <= '0;
         cout_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         a_q     <= a_d;
         b_q     <= b_d;
         sub_q   <= sub_d;
         carry_q <= carry_d;
         idx_q   <= idx_d;
         res_q   <= res_d;
         out_q   <= out_d;
         cout_q  <= cout_d;
         done_q  <= done_d;
      end
   end

`ifdef SEQ_CHUNK_ADDR_OVF_EN
   logic ovf_q, ovf_d;

   always_comb begin
      ovf_d = ovf_q;
      if (state_q == BUSY && last) ovf_d = c[CHUNK-1] ^ c[CHUNK];
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) ovf_q <= 1'b0;
      else     ovf_q <= ovf_d;
   end

   assign ovf = ovf_q;
`else
   assign ovf = 1'b0;
`endif

   assign busy = (state_q == BUSY);
   assign done = done_q;
   assign out  = out_q;
   assign cout = cout_q;

endmodule

// File: tb/tb_seq_chunk_addr.sv
// Scoreboard bench for seq_chunk_addr (WIDTH=16, CHUNK=4): expected results queued at issue.
module tb_seq_chunk_addr;
   localparam int W = 16;
   localparam int C = 4;
   localparam int N = W / C;

   logic         clk = 1'b0;
   logic         rst, start, sub, cin;
   logic [W-1:0] in1, in2, out;
   logic         busy, done, cout, ovf;

   typedef struct packed {
      logic [W-1:0] out;
      logic         cout;
      logic         ovf;
   } exp_t;

   exp_t sb[$];
   int   vectors = 0;
   int   miscompares = 0;

   always #5 clk = ~clk;

   seq_chunk_addr #(.WIDTH(W), .CHUNK(C)) dut (
      .clk(clk), .rst(rst), .start(start), .sub(sub), .in1(in1), .in2(in2),
      .cin(cin), .busy(busy), .done(done), .out(out), .cout(cout), .ovf(ovf)
   );

   function automatic exp_t model(input logic s, input logic [W-1:0] a, input logic [W-1:0] b,
                                  input logic c);
      logic [W:0]   full;
      logic [W-1:0] bb;
      logic         ci;
      exp_t         e;
      bb     = s ? ~b : b;
      ci     = s ? 1'b1 : c;
      full   = {1'b0, a} + {1'b0, bb} + {{W{1'b0}}, ci};
      e.out  = full[W-1:0];
      e.cout = full[W];
`ifdef SEQ_CHUNK_ADDR_OVF_EN
      e.ovf  = (a[W-1] == bb[W-1]) && (e.out[W-1] != a[W-1]);
`else
      e.ovf  = 1'b0;
`endif
      return e;
   endfunction

   // Called at a negedge; returns at the negedge following the accepting edge.
   task automatic issue(input logic s, input logic [W-1:0] a, input logic [W-1:0] b, input logic c);
      sb.push_back(model(s, a, b, c));
      start = 1'b1; sub = s; in1 = a; in2 = b; cin = c;
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic wait_done(output int lat, output int bcnt);
      lat = 0; bcnt = 0;
      while (done !== 1'b1 && lat < 20) begin
         if (busy === 1'b1) bcnt++;
         @(negedge clk);
         lat++;
      end
   endtask

   task automatic test_reset();
      rst = 1'b1; start = 1'b0; sub = 1'b0; cin = 1'b0; in1 = '0; in2 = '0;
      #2;
      vectors++;
      if ({busy, done, out, cout, ovf} !== '0) begin
         miscompares++;
         $display("FAIL reset_state: got busy=%b done=%b out=%h cout=%b ovf=%b, want all 0",
                  busy, done, out, cout, ovf);
      end
      repeat (2) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      vectors++;
      if ({busy, done} !== 2'b00) begin
         miscompares++;
         $display("FAIL reset_release: got busy=%b done=%b, want 0 0", busy, done);
      end
   endtask

   task automatic test_add_basic();
      int lat, bc; exp_t e;
      @(negedge clk);
      issue(1'b0, 16'h00FF, 16'h0001, 1'b0);
      wait_done(lat, bc);
      vectors++;
      if (lat !== N || bc !== N) begin
         miscompares++;
         $display("FAIL add_latency: got done_at=%0d busy_cycles=%0d, want %0d %0d", lat, bc, N, N);
      end
      e = (sb.size() > 0) ? sb.pop_front() : '0;
      vectors++;
      if ({out, cout, ovf} !== {e.out, e.cout, e.ovf} || out !== 16'h0100) begin
         miscompares++;
         $display("FAIL add_basic: got %h/%b/%b, want %h/%b/%b", out, cout, ovf, e.out, e.cout, e.ovf);
      end
      @(negedge clk);
      vectors++;
      if (done !== 1'b0 || out !== 16'h0100) begin
         miscompares++;
         $display("FAIL done_pulse_hold: got done=%b out=%h, want 0 0100", done, out);
      end
   endtask

   task automatic run_one(input string name, input logic s, input logic [W-1:0] a,
                          input logic [W-1:0] b, input logic c);
      int lat, bc; exp_t e;
      @(negedge clk);
      issue(s, a, b, c);
      wait_done(lat, bc);
      e = (sb.size() > 0) ? sb.pop_front() : '0;
      vectors++;
      if (lat !== N || {out, cout, ovf} !== {e.out, e.cout, e.ovf}) begin
         miscompares++;
         $display("FAIL %s: got lat=%0d %h/%b/%b, want lat=%0d %h/%b/%b",
                  name, lat, out, cout, ovf, N, e.out, e.cout, e.ovf);
      end
   endtask

   task automatic test_carry();
      run_one("carry_wrap", 1'b0, 16'hFFFF, 16'h0001, 1'b0);
      vectors++;
      if (out !== 16'h0000 || cout !== 1'b1) begin
         miscompares++;
         $display("FAIL carry_wrap_const: got %h/%b, want 0000/1", out, cout);
      end
      run_one("carry_in", 1'b0, 16'h0000, 16'h0000, 1'b1);
      vectors++;
      if (out !== 16'h0001 || cout !== 1'b0) begin
         miscompares++;
         $display("FAIL carry_in_const: got %h/%b, want 0001/0", out, cout);
      end
   endtask

   task automatic test_sub();
      run_one("sub_neg", 1'b1, 16'h0005, 16'h0007, 1'b0);
      vectors++;
      if (out !== 16'hFFFE || cout !== 1'b0) begin
         miscompares++;
         $display("FAIL sub_neg_const: got %h/%b, want FFFE/0", out, cout);
      end
      run_one("sub_pos", 1'b1, 16'h0007, 16'h0005, 1'b1);
      vectors++;
      if (out !== 16'h0002 || cout !== 1'b1) begin
         miscompares++;
         $display("FAIL sub_pos_const: got %h/%b, want 0002/1", out, cout);
      end
   endtask

   task automatic test_ovf();
      run_one("ovf_add", 1'b0, 16'h7FFF, 16'h0001, 1'b0);
      run_one("ovf_sub", 1'b1, 16'h8000, 16'h0001, 1'b0);
      run_one("no_ovf_mix", 1'b0, 16'h8000, 16'h7FFF, 1'b1);
   endtask

   task automatic test_busy_ignore();
      int n_done; exp_t e;
      @(negedge clk);
      issue(1'b0, 16'h1111, 16'h2222, 1'b0);
      start = 1'b1; sub = 1'b1; in1 = 16'hFFFF; in2 = 16'h0001; cin = 1'b1;
      repeat (2) @(negedge clk);
      start = 1'b0;
      n_done = 0;
      for (int i = 0; i < 15; i++) begin
         if (done === 1'b1) begin
            n_done++;
            if (n_done == 1) begin
               e = (sb.size() > 0) ? sb.pop_front() : '0;
               vectors++;
               if ({out, cout, ovf} !== {e.out, e.cout, e.ovf}) begin
                  miscompares++;
                  $display("FAIL busy_ignore_result: got %h/%b/%b, want %h/%b/%b",
                           out, cout, ovf, e.out, e.cout, e.ovf);
               end
            end
         end
         @(negedge clk);
      end
      vectors++;
      if (n_done !== 1) begin
         miscompares++;
         $display("FAIL busy_ignore_done_count: got %0d, want 1", n_done);
      end
   endtask

   task automatic test_back_to_back();
      int lat, bc; exp_t e;
      @(negedge clk);
      issue(1'b0, 16'h0010, 16'h0020, 1'b0);
      wait_done(lat, bc);
      e = (sb.size() > 0) ? sb.pop_front() : '0;
      vectors++;
      if ({out, cout, ovf} !== {e.out, e.cout, e.ovf}) begin
         miscompares++;
         $display("FAIL b2b_first: got %h/%b/%b, want %h/%b/%b", out, cout, ovf, e.out, e.cout, e.ovf);
      end
      issue(1'b1, 16'h0100, 16'h0001, 1'b0);
      wait_done(lat, bc);
      e = (sb.size() > 0) ? sb.pop_front() : '0;
      vectors++;
      if (lat + 1 !== N + 1) begin
         miscompares++;
         $display("FAIL b2b_spacing: got %0d cycles between dones, want %0d", lat + 1, N + 1);
      end
      vectors++;
      if ({out, cout, ovf} !== {e.out, e.cout, e.ovf}) begin
         miscompares++;
         $display("FAIL b2b_second: got %h/%b/%b, want %h/%b/%b", out, cout, ovf, e.out, e.cout, e.ovf);
      end
   endtask

   task automatic test_mid_reset();
      int n_done, lat, bc; exp_t e;
      @(negedge clk);
      issue(1'b0, 16'h0F0F, 16'h0101, 1'b0);
      @(negedge clk);
      #1 rst = 1'b1;
      #1;
      vectors++;
      if ({busy, done, out, cout, ovf} !== '0) begin
         miscompares++;
         $display("FAIL mid_reset_clear: got busy=%b done=%b out=%h cout=%b ovf=%b, want all 0",
                  busy, done, out, cout, ovf);
      end
      @(negedge clk);
      rst = 1'b0;
      sb.delete();
      n_done = 0;
      for (int i = 0; i < 8; i++) begin
         if (done === 1'b1 || busy === 1'b1) n_done++;
         @(negedge clk);
      end
      vectors++;
      if (n_done !== 0) begin
         miscompares++;
         $display("FAIL mid_reset_abandon: got %0d busy/done cycles, want 0", n_done);
      end
      issue(1'b0, 16'h1234, 16'h1111, 1'b0);
      wait_done(lat, bc);
      e = (sb.size() > 0) ? sb.pop_front() : '0;
      vectors++;
      if (lat !== N || out !== 16'h2345 || {out, cout, ovf} !== {e.out, e.cout, e.ovf}) begin
         miscompares++;
         $display("FAIL after_reset_op: got lat=%0d %h/%b/%b, want lat=%0d 2345/%b/%b",
                  lat, out, cout, ovf, N, e.cout, e.ovf);
      end
   endtask

   task automatic test_random();
      for (int i = 0; i < 12; i++)
         run_one("random", 1'($urandom_range(0, 1)), 16'($urandom), 16'($urandom),
                 1'($urandom_range(0, 1)));
   endtask

   initial begin
      test_reset();
      test_add_basic();
      test_carry();
      test_sub();
      test_ovf();
      test_busy_ignore();
      test_back_to_back();
      test_mid_reset();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached, want completion");
      $fatal(1, "watchdog");
   end

endmodule
